// File: rtl/pipeline_control.sv
// Pipeline hazard/flush/halt controller for a 5-stage in-order pipeline.
// Produces PC and stage-register enables and flushes from the load-use
// hazard, the taken-branch indication and the data-memory freeze. It also
// sequences a drain-then-halt: bubbles are fed until ID/EX/MEM/WB are
// empty, and then the pipeline parks until resume.
// Optional feature: define PIPELINE_CONTROL_PERF_COUNTERS_EN to build the
// saturating stall/flush performance counters. Without it they read zero.
module pipeline_control #(
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_reg_dest,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        halt_req,
  input  logic        resume_req,
  input  logic        counter_clear,
  output logic        pc_enable,
  output logic        pc_load_target,
  output logic        if_id_enable,
  output logic        id_ex_enable,
  output logic        ex_mem_enable,
  output logic        mem_wb_enable,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        halted,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] drain_cnt_q, drain_cnt_d;
  logic       halt_pend_q, halt_pend_d;

  logic freeze;
  logic load_use;
  logic stall_evt;
  logic flush_evt;

  assign freeze   = mem_req & ~mem_ready;
  assign load_use = ex_mem_read && (ex_reg_dest != 5'd0) &&
                    ((ex_reg_dest == id_rs) || (id_uses_rt && (ex_reg_dest == id_rt)));

  // Cycles lost to freeze or load-use bubble, and taken-branch redirects.
  assign stall_evt = (state_q != ST_HALTED) &&
                     (freeze || ((state_q == ST_RUN) && !branch_taken && load_use));
  assign flush_evt = (state_q != ST_HALTED) && !freeze && branch_taken;

  assign halted = (state_q == ST_HALTED);

  // State, drain counter and pending-halt register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= 3'd0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  // Next-state and enable/flush decode; freeze overrides all else outside HALTED.
  always_comb begin
    state_d        = state_q;
    drain_cnt_d    = drain_cnt_q;
    halt_pend_d    = halt_pend_q;
    pc_enable      = 1'b1;
    pc_load_target = 1'b0;
    if_id_enable   = 1'b1;
    id_ex_enable   = 1'b1;
    ex_mem_enable  = 1'b1;
    mem_wb_enable  = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_flush   = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (freeze) begin
          pc_enable     = 1'b0;
          if_id_enable  = 1'b0;
          id_ex_enable  = 1'b0;
          ex_mem_enable = 1'b0;
          mem_wb_enable = 1'b0;
          if (halt_req) halt_pend_d = 1'b1;
        end else begin
          if (branch_taken) begin
            pc_load_target = 1'b1;
            if_id_flush    = 1'b1;
            id_ex_flush    = 1'b1;
            ex_mem_flush   = 1'b1;
          end else if (load_use) begin
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            id_ex_flush  = 1'b1;
          end
          if (halt_req || halt_pend_q) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = 3'd0;
            halt_pend_d = 1'b0;
          end
        end
      end

      ST_DRAIN: begin
        if (freeze) begin
          pc_enable     = 1'b0;
          if_id_enable  = 1'b0;
          id_ex_enable  = 1'b0;
          ex_mem_enable = 1'b0;
          mem_wb_enable = 1'b0;
        end else begin
          pc_enable   = 1'b0;
          if_id_flush = 1'b1;
          if (branch_taken) begin
            pc_enable      = 1'b1;
            pc_load_target = 1'b1;
            id_ex_flush    = 1'b1;
            ex_mem_flush   = 1'b1;
          end
          if (drain_cnt_q == DRAIN_LAST) begin
            state_d     = ST_HALTED;
            drain_cnt_d = 3'd0;
          end else begin
            drain_cnt_d = drain_cnt_q + 3'd1;
          end
        end
      end

      ST_HALTED: begin
        pc_enable     = 1'b0;
        if_id_enable  = 1'b0;
        id_ex_enable  = 1'b0;
        ex_mem_enable = 1'b0;
        mem_wb_enable = 1'b0;
        if (resume_req) state_d = ST_RUN;
      end

      default: begin
        state_d     = ST_RUN;
        drain_cnt_d = 3'd0;
        halt_pend_d = 1'b0;
      end
    endcase
  end

`ifdef PIPELINE_CONTROL_PERF_COUNTERS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  // Saturating performance counters; clear takes priority over counting.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else if (counter_clear) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (stall_evt) stall_cnt_q <= sat_inc(stall_cnt_q);
      if (flush_evt) flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
`else
  logic unused_perf;
  assign unused_perf  = &{1'b0, counter_clear, stall_evt, flush_evt};
  assign stall_cycles = 16'd0;
  assign flush_count  = 16'd0;
`endif

endmodule
